div_tick_timer: RTL and testbench
=================================

Name: div_tick_timer

Overview:
Programmable down-counting timer downstream of the 8-bit clock divider. Takes the divider's output level `div_in`, detects its edges in the `clk` domain and turns them into single-cycle ticks. Counts a loaded number of ticks, then emits a one-cycle `done` pulse, with optional auto-reload. Used to build slow timebases such as LED blink periods or seconds counters from the divided clock.

Parameters:
- WIDTH, 8, width of the tick counter, `load_val` and `count`.
- BOTH_EDGES, 0, 0 = tick on rising edges of `div_in` only; 1 = tick on both edges.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- div_in  input  1  divided-clock level from the upstream divider.
- load_val  input  WIDTH  terminal tick count; sampled on accepted `start`.
- start  input  1  load and run; one-cycle strobe or held level.
- pause  input  1  level; while high in RUN/PAUSE, ticks are ignored.
- abort  input  1  return to IDLE, count cleared, no `done`.
- auto_reload  input  1  sampled with `start`; 1 = restart after each expiry.
- count  output  WIDTH  remaining ticks.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on expiry.
- tick_out  output  1  one-cycle registered pulse per detected edge, in every state.

Behaviour:
- Reset is asynchronous and applies immediately, including mid-count.
  - count=0, busy=0, done=0, tick_out=0, state=IDLE.
  - Edge-detect history=0 and armed=0.
- Edge detect: sample register `div_s` (= `div_in`, or synchronizer output) and history register `div_d`.
  - armed=0 for the first clock after reset. That clock only loads `div_d`, so no false edge occurs if `div_in` is high at reset release.
  - tick = armed & (BOTH_EDGES ? div_s^div_d : div_s&~div_d).
  - Latency: edge k is when `div_s` first shows the new level. At edge k+1, `count` decrements and `tick_out` pulses.
- Internal register `reload_val`[WIDTH] and `reload_mode` are captured on accepted `start`.
- Priority within a cycle: abort > start > pause > tick.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE:
    - start with load_val≠0 → RUN; count=load_val, busy=1 from the next cycle.
    - start with load_val=0 → done=1 for one cycle, stay IDLE, count=0.
    - Ticks are ignored.
  - RUN:
    - pause=1 → PAUSE; a tick in that same cycle is ignored.
    - tick with count>1 → count-1.
    - tick with count=1 → done=1 for one cycle. If reload_mode=1: count=reload_val, stay RUN. Otherwise: count=0, go to IDLE, busy=0.
  - PAUSE:
    - count is held and ticks are dropped, not queued.
    - pause=0 → RUN; the first tick is counted from the next cycle.
  - start in RUN or PAUSE: restart with the new load_val/auto_reload. No done is emitted for the interrupted run.
  - abort in any state: IDLE, count=0, busy=0, done=0.
- Counter never wraps: a decrement from 0 cannot occur because RUN never holds count=0.
- done and tick_out are registered single-cycle pulses. Consecutive ticks one cycle apart, which is possible when BOTH_EDGES=1, are each counted.

Optional Feature:
DIV_SYNC_EN
- Defined: `div_in` passes through a two-flop synchronizer, reset to 0, before `div_s`.
  - Edge-to-decrement latency becomes 3 clk edges.
  - armed stays 0 until the synchronizer has been loaded: 3 clocks after reset release.
- Undefined: `div_in` is sampled directly into `div_s` and is assumed synchronous to `clk`. Latency is as stated above.

Test Plan:
1. Basic count. WIDTH=8, BOTH_EDGES=0; `div_in` toggles every 4 clk; start with load_val=3, auto_reload=0 → count goes 3,2,1,0. done pulses once, exactly 1 clk after the 3rd rising edge is sampled. busy falls with done; tick_out pulses on every rising edge.
2. Auto-reload. load_val=2, auto_reload=1, 6 rising edges → done pulses after edges 2, 4 and 6. count sequence is 2,1,2,1,2,1,2; busy stays 1.
3. Pause/abort. load_val=5; pause high across 2 rising edges after the first decrement → count holds at 4, then resumes to 0 after 4 more edges. A separate run aborted at count=3 → count=0, busy=0, no done.
4. Edge cases. start with load_val=0 → single done, busy never rises. `div_in` held high through reset release → no tick, count unchanged. start asserted in the same cycle as a tick in RUN → reload wins, no decrement.
5. BOTH_EDGES=1 with `div_in` toggling every clk, load_val=4 → done 4 ticks later, i.e. 4 consecutive decrements.
6. Async reset mid-run at count=7 → all outputs go to 0 before the next clk edge. With DIV_SYNC_EN defined, rerun scenario 1 and check the decrement latency is 3 clk.

Source files
------------

// File: rtl/div_tick_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : div_tick_timer_if
// Purpose  : Control/status bundle between a host and div_tick_timer.
// Revision : 1.0 - initial release
// ============================================================================
interface div_tick_timer_if #(
  parameter int WIDTH = 8
) ();
  logic             div_in;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tick_out;

  modport master (
    output div_in, load_val, start, pause, abort, auto_reload,
    input  count, busy, done, tick_out
  );

  modport slave (
    input  div_in, load_val, start, pause, abort, auto_reload,
    output count, busy, done, tick_out
  );
endinterface
`default_nettype wire

// File: rtl/div_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : div_tick_timer
// Purpose  : Down-counts edges of a divided clock level; pulses done on expiry.
//            Optional DIV_SYNC_EN adds a two-flop synchronizer on div_in.
// Revision : 1.0 - initial release
// ============================================================================
module div_tick_timer #(
  parameter int WIDTH      = 8,
  parameter bit BOTH_EDGES = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  div_tick_timer_if.slave bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_pause = 2'd2;

`ifdef DIV_SYNC_EN
  localparam logic [1:0] c_arm_last = 2'd2;
`else
  localparam logic [1:0] c_arm_last = 2'd0;
`endif

  logic             w_div_s_nxt;
  logic             r_div_s;
  logic             r_div_d;
  logic             r_armed;
  logic [1:0]       r_arm_cnt;
  logic             w_edge;
  logic             w_tick;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload_val;
  logic             r_reload_mode;
  logic             r_done;
  logic             r_tick_out;

`ifdef DIV_SYNC_EN
  logic r_sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync1 <= 1'b0;
    else     r_sync1 <= bus.div_in;
  end

  assign w_div_s_nxt = r_sync1;
`else
  assign w_div_s_nxt = bus.div_in;
`endif

  // While unarmed the history is primed with the incoming sample, so a level
  // already high at reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_s   <= 1'b0;
      r_div_d   <= 1'b0;
      r_armed   <= 1'b0;
      r_arm_cnt <= 2'd0;
    end else begin
      r_div_s <= w_div_s_nxt;
      r_div_d <= r_armed ? r_div_s : w_div_s_nxt;
      if (!r_armed) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
        r_armed   <= (r_arm_cnt == c_arm_last);
      end
    end
  end

  generate
    if (BOTH_EDGES) begin : g_both_edges
      assign w_edge = r_div_s ^ r_div_d;
    end else begin : g_rise_edge
      assign w_edge = r_div_s & ~r_div_d;
    end
  endgenerate

  assign w_tick = r_armed & w_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_st_idle;
      r_count       <= '0;
      r_reload_val  <= '0;
      r_reload_mode <= 1'b0;
      r_done        <= 1'b0;
      r_tick_out    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tick_out <= w_tick;
      if (bus.abort) begin
        r_state <= c_st_idle;
        r_count <= '0;
      end else if (bus.start) begin
        r_reload_val  <= bus.load_val;
        r_reload_mode <= bus.auto_reload;
        if (bus.load_val == '0) begin
          // Zero-length run expires immediately without ever going busy.
          r_done  <= 1'b1;
          r_state <= c_st_idle;
          r_count <= '0;
        end else begin
          r_state <= c_st_run;
          r_count <= bus.load_val;
        end
      end else begin
        case (r_state)
          c_st_run: begin
            if (bus.pause) begin
              r_state <= c_st_pause;
            end else if (w_tick) begin
              if (r_count == WIDTH'(1)) begin
                r_done <= 1'b1;
                if (r_reload_mode) begin
                  r_count <= r_reload_val;
                end else begin
                  r_count <= '0;
                  r_state <= c_st_idle;
                end
              end else begin
                r_count <= r_count - WIDTH'(1);
              end
            end
          end
          c_st_pause: begin
            if (!bus.pause) r_state <= c_st_run;
          end
          c_st_idle: begin
            r_state <= c_st_idle;
          end
          default: begin
            r_state <= c_st_idle;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.busy     = (r_state != c_st_idle);
  assign bus.done     = r_done;
  assign bus.tick_out = r_tick_out;

endmodule
`default_nettype wire

// File: tb/tb_div_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_tick_timer
// Purpose  : Scoreboard bench; expected tick/done events queued by stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_tick_timer;

`ifdef DIV_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_tick_timer_if #(.WIDTH(8)) ifa ();
  div_tick_timer_if #(.WIDTH(8)) ifb ();

  div_tick_timer #(.WIDTH(8), .BOTH_EDGES(1'b0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  div_tick_timer #(.WIDTH(8), .BOTH_EDGES(1'b1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int total = 0;
  int bad   = 0;
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  logic [10:0] got_a, exp_a, got_b, exp_b;

  // Event record: {tick_out, done, count[7:0], busy}
  function automatic logic [10:0] ev(input bit t, input bit d, input int c, input bit b);
    return {t, d, 8'(c), b};
  endfunction

  always @(negedge clk) begin
    if (!rst && (ifa.tick_out || ifa.done)) begin
      got_a = {ifa.tick_out, ifa.done, ifa.count, ifa.busy};
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL evA unexpected t/d/cnt/busy got=%0d/%0d/%0d/%0d want=none",
                 got_a[10], got_a[9], got_a[8:1], got_a[0]);
      end else begin
        exp_a = qa.pop_front();
        if (got_a !== exp_a) begin
          bad++;
          $display("FAIL evA t/d/cnt/busy got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                   got_a[10], got_a[9], got_a[8:1], got_a[0],
                   exp_a[10], exp_a[9], exp_a[8:1], exp_a[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (ifb.tick_out || ifb.done)) begin
      got_b = {ifb.tick_out, ifb.done, ifb.count, ifb.busy};
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL evB unexpected t/d/cnt/busy got=%0d/%0d/%0d/%0d want=none",
                 got_b[10], got_b[9], got_b[8:1], got_b[0]);
      end else begin
        exp_b = qb.pop_front();
        if (got_b !== exp_b) begin
          bad++;
          $display("FAIL evB t/d/cnt/busy got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                   got_b[10], got_b[9], got_b[8:1], got_b[0],
                   exp_b[10], exp_b[9], exp_b[8:1], exp_b[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int lv, input bit ar);
    ifa.load_val = 8'(lv); ifa.auto_reload = ar; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
  endtask

  task automatic abort_a();
    ifa.abort = 1'b1;
    step();
    ifa.abort = 1'b0;
  endtask

  // One div_in period on DUT A: 4 clocks high, 4 low.
  task automatic pulse(input bit chk_lat);
    int lat;
    lat = 0;
    ifa.div_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (lat == 0 && ifa.tick_out) lat = i;
    end
    ifa.div_in = 1'b0;
    repeat (4) step();
    if (chk_lat) chk("edge_to_tick_latency", lat, LAT);
  endtask

  initial begin
    ifa.div_in = 1'b0; ifa.load_val = '0; ifa.start = 1'b0;
    ifa.pause = 1'b0;  ifa.abort = 1'b0;  ifa.auto_reload = 1'b0;
    ifb.div_in = 1'b0; ifb.load_val = '0; ifb.start = 1'b0;
    ifb.pause = 1'b0;  ifb.abort = 1'b0;  ifb.auto_reload = 1'b0;

    step();
    chk("reset_count", int'(ifa.count), 0);
    chk("reset_busy", int'(ifa.busy), 0);
    chk("reset_done", int'(ifa.done), 0);
    chk("reset_tick", int'(ifa.tick_out), 0);
    rst = 1'b0;
    repeat (4) step();

    // Basic count 3 -> 0, then a tick while idle
    start_a(3, 1'b0);
    chk("t1_load_count", int'(ifa.count), 3);
    chk("t1_load_busy", int'(ifa.busy), 1);
    qa.push_back(ev(1, 0, 2, 1));
    qa.push_back(ev(1, 0, 1, 1));
    qa.push_back(ev(1, 1, 0, 0));
    qa.push_back(ev(1, 0, 0, 0));
    for (int i = 0; i < 4; i++) pulse(1'b1);

    // Auto-reload
    start_a(2, 1'b1);
    chk("t2_load_count", int'(ifa.count), 2);
    for (int i = 0; i < 3; i++) begin
      qa.push_back(ev(1, 0, 1, 1));
      qa.push_back(ev(1, 1, 2, 1));
    end
    for (int i = 0; i < 6; i++) pulse(1'b0);
    chk("t2_busy_held", int'(ifa.busy), 1);
    abort_a();
    chk("t2_abort_count", int'(ifa.count), 0);
    chk("t2_abort_busy", int'(ifa.busy), 0);

    // Pause across two edges, then resume
    start_a(5, 1'b0);
    qa.push_back(ev(1, 0, 4, 1));
    pulse(1'b0);
    ifa.pause = 1'b1;
    qa.push_back(ev(1, 0, 4, 1));
    qa.push_back(ev(1, 0, 4, 1));
    pulse(1'b0);
    pulse(1'b0);
    ifa.pause = 1'b0;
    step();
    chk("t3_pause_hold", int'(ifa.count), 4);
    qa.push_back(ev(1, 0, 3, 1));
    qa.push_back(ev(1, 0, 2, 1));
    qa.push_back(ev(1, 0, 1, 1));
    qa.push_back(ev(1, 1, 0, 0));
    for (int i = 0; i < 4; i++) pulse(1'b0);

    // Abort at count=3
    start_a(5, 1'b0);
    qa.push_back(ev(1, 0, 4, 1));
    qa.push_back(ev(1, 0, 3, 1));
    pulse(1'b0);
    pulse(1'b0);
    chk("t3_pre_abort", int'(ifa.count), 3);
    abort_a();
    chk("t3_abort_count", int'(ifa.count), 0);
    chk("t3_abort_busy", int'(ifa.busy), 0);
    chk("t3_abort_done", int'(ifa.done), 0);
    repeat (3) step();

    // load_val=0: immediate done, never busy
    qa.push_back(ev(0, 1, 0, 0));
    start_a(0, 1'b0);
    chk("t4_zero_busy", int'(ifa.busy), 0);
    step();
    chk("t4_zero_busy_later", int'(ifa.busy), 0);

    // div_in held high through reset release: no false tick
    ifa.div_in = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    chk("t4_high_reset_count", int'(ifa.count), 0);
    ifa.div_in = 1'b0;
    repeat (4) step();

    // start coincident with a tick in RUN: reload wins
    start_a(3, 1'b0);
    qa.push_back(ev(1, 0, 2, 1));
    pulse(1'b0);
    qa.push_back(ev(1, 0, 6, 1));
    ifa.div_in = 1'b1;
    repeat (LAT - 1) step();
    ifa.load_val = 8'd6; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    chk("t4_start_vs_tick", int'(ifa.count), 6);
    repeat (4 - LAT) step();
    ifa.div_in = 1'b0;
    repeat (4) step();
    abort_a();

    // BOTH_EDGES=1, div_in toggling every clock
    ifb.load_val = 8'd4; ifb.auto_reload = 1'b0; ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    chk("t5_load_count", int'(ifb.count), 4);
    qb.push_back(ev(1, 0, 3, 1));
    qb.push_back(ev(1, 0, 2, 1));
    qb.push_back(ev(1, 0, 1, 1));
    qb.push_back(ev(1, 1, 0, 0));
    qb.push_back(ev(1, 0, 0, 0));
    qb.push_back(ev(1, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      ifb.div_in = ~ifb.div_in;
      step();
    end
    repeat (5) step();

    // Asynchronous reset mid-run
    start_a(7, 1'b0);
    chk("t6_pre_count", int'(ifa.count), 7);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_count", int'(ifa.count), 0);
    chk("t6_async_busy", int'(ifa.busy), 0);
    chk("t6_async_done", int'(ifa.done), 0);
    chk("t6_async_tick", int'(ifa.tick_out), 0);
    step();
    rst = 1'b0;
    repeat (6) step();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
